// File: rtl/mdu.sv
// mdu: multiply/divide unit holding the HI/LO registers.
// Define MDU_FAST_MULT_EN for a single-cycle array multiplier.
module mdu #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        mult,
    input  logic        div,
    input  logic        mdsign,
    input  logic [1:0]  hilowen,
    input  logic [1:0]  hiloren,
    input  logic [31:0] rega,
    input  logic [31:0] regb,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hilo_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [5:0] LAST   = 6'(DIV_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        neg_q_q, neg_q_d;
    logic        neg_r_q, neg_r_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        idle, last, mult_iter;
    logic        issue_mul, issue_div;
    logic [31:0] a_abs, b_abs;
    logic [32:0] mul_sum, div_diff;
    logic [63:0] mul_nxt, div_nxt, mul_res;
    logic [31:0] quo, rem;

`ifdef MDU_FAST_MULT_EN
    logic signed [63:0] fast_prod;
    assign fast_prod = $signed({mdsign & rega[31], rega})
                     * $signed({mdsign & regb[31], regb});
    assign mult_iter = 1'b0;
`else
    assign mult_iter = mult;
`endif

    assign idle      = (state_q == S_IDLE);
    assign last      = (cnt_q == LAST);
    assign issue_mul = idle & en & mult_iter & ~flush;
    assign issue_div = idle & en & div & ~flush;
    assign busy      = issue_mul | issue_div | (~idle & ~last & ~flush);

    assign a_abs = (mdsign & rega[31]) ? -rega : rega;
    assign b_abs = (mdsign & regb[31]) ? -regb : regb;

    // Shift-add: upper half accumulates, multiplier drains out the bottom.
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    assign mul_nxt = {mul_sum, acc_q[31:1]};
    assign mul_res = neg_q_q ? -mul_nxt : mul_nxt;

    // Restoring step: {remainder, quotient} shifts left one bit per cycle.
    assign div_diff = acc_q[63:31] - {1'b0, b_q};
    assign div_nxt  = div_diff[32] ? {acc_q[62:0], 1'b0}
                                   : {div_diff[31:0], acc_q[30:0], 1'b1};
    assign quo = neg_q_q ? -div_nxt[31:0]  : div_nxt[31:0];
    assign rem = neg_r_q ? -div_nxt[63:32] : div_nxt[63:32];

    assign hi = hi_q;
    assign lo = lo_q;
    assign hilo_rdata = hiloren[1] ? hi_q : hiloren[0] ? lo_q : 32'd0;

    // Next-state: issue, iterate, commit, and direct HI/LO writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (issue_mul || issue_div) begin
                    state_d = issue_div ? S_DIV : S_MUL;
                    cnt_d   = 6'd0;
                    a_d     = a_abs;
                    b_d     = b_abs;
                    neg_q_d = mdsign & (rega[31] ^ regb[31]);
                    neg_r_d = mdsign & rega[31];
                    acc_d   = issue_div ? {32'd0, a_abs} : {32'd0, b_abs};
                end else if (en && !flush && !mult && !div) begin
                    if (hilowen[1]) hi_d = rega;
                    if (hilowen[0]) lo_d = rega;
                end
`ifdef MDU_FAST_MULT_EN
                else if (en && !flush && mult) begin
                    {hi_d, lo_d} = fast_prod;
                end
`endif
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = 6'd0;
                end else begin
                    acc_d = mul_nxt;
                    cnt_d = cnt_q + 6'd1;
                    if (last) begin
                        state_d      = S_IDLE;
                        cnt_d        = 6'd0;
                        {hi_d, lo_d} = mul_res;
                    end
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = 6'd0;
                end else begin
                    acc_d = div_nxt;
                    cnt_d = cnt_q + 6'd1;
                    if (last) begin
                        state_d = S_IDLE;
                        cnt_d   = 6'd0;
                        hi_d    = rem;
                        lo_d    = quo;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // State registers, cleared asynchronously so reset aborts at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            acc_q   <= 64'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed self-checking bench for the mdu.
// Covers multiply, divide, corner cases, flush and reset.
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, mult, div, mdsign, flush;
    logic [1:0]  hilowen, hiloren;
    logic [31:0] rega, regb;
    logic        busy;
    logic [31:0] hilo_rdata, hi, lo;

    int total  = 0;
    int passed = 0;

`ifdef MDU_FAST_MULT_EN
    localparam int MUL_CYC = 0;
`else
    localparam int MUL_CYC = 32;
`endif

    always #5 clk = ~clk;

    mdu dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mult       (mult),
        .div        (div),
        .mdsign     (mdsign),
        .hilowen    (hilowen),
        .hiloren    (hiloren),
        .rega       (rega),
        .regb       (regb),
        .flush      (flush),
        .busy       (busy),
        .hilo_rdata (hilo_rdata),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        en = 0; mult = 0; div = 0; mdsign = 0;
        hilowen = 2'b00; hiloren = 2'b00;
        rega = 0; regb = 0; flush = 0;
    endtask

    // Issue one mult/div and wait for commit; cyc = busy cycles seen.
    task automatic run_op(input logic m, input logic d, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        en = 1; mult = m; div = d; mdsign = s;
        hilowen = 2'b11; rega = a; regb = b;
        #1;
        cyc = busy ? 1 : 0;
        tick;
        idle_in;
        #1;
        if (cyc != 0) begin
            while (busy && cyc < 100) begin
                cyc++;
                tick;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        idle_in;
        rst = 1;
        hiloren = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (hi !== 32'd0) $display("FAIL reset_hi: got %h expected 0", hi); else passed++;
        total++; if (lo !== 32'd0) $display("FAIL reset_lo: got %h expected 0", lo); else passed++;
        total++; if (hilo_rdata !== 32'd0) $display("FAIL reset_rdata: got %h expected 0", hilo_rdata); else passed++;
        hiloren = 2'b00;
        tick;
    endtask

    task automatic test_direct;
        en = 1; hilowen = 2'b10; rega = 32'hDEADBEEF;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %b expected 0", busy); else passed++;
        tick;
        idle_in;
        #1;
        total++; if (hi !== 32'hDEADBEEF) $display("FAIL mthi_hi: got %h expected deadbeef", hi); else passed++;
        total++; if (lo !== 32'd0) $display("FAIL mthi_lo: got %h expected 0", lo); else passed++;
        en = 1; hilowen = 2'b01; rega = 32'h0BADF00D;
        tick;
        idle_in;
        #1;
        total++; if (lo !== 32'h0BADF00D) $display("FAIL mtlo_lo: got %h expected 0badf00d", lo); else passed++;
        total++; if (hi !== 32'hDEADBEEF) $display("FAIL mtlo_hi: got %h expected deadbeef", hi); else passed++;
    endtask

    task automatic test_multu;
        int c;
        run_op(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, c);
        total++; if (c != MUL_CYC) $display("FAIL multu_cycles: got %0d expected %0d", c, MUL_CYC); else passed++;
        total++; if (hi !== 32'hFFFFFFFE) $display("FAIL multu_hi: got %h expected fffffffe", hi); else passed++;
        total++; if (lo !== 32'h00000001) $display("FAIL multu_lo: got %h expected 00000001", lo); else passed++;
    endtask

    task automatic test_mult_mfhi;
        int c;
        run_op(1, 0, 1, 32'hFFFFFFFD, 32'd5, c);
        total++; if (c != MUL_CYC) $display("FAIL mult_cycles: got %0d expected %0d", c, MUL_CYC); else passed++;
        total++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h expected ffffffff", hi); else passed++;
        total++; if (lo !== 32'hFFFFFFF1) $display("FAIL mult_lo: got %h expected fffffff1", lo); else passed++;
        en = 1; hiloren = 2'b10;
        #1;
        total++; if (hilo_rdata !== 32'hFFFFFFFF) $display("FAIL mfhi_rdata: got %h expected ffffffff", hilo_rdata); else passed++;
        hiloren = 2'b01;
        #1;
        total++; if (hilo_rdata !== 32'hFFFFFFF1) $display("FAIL mflo_rdata: got %h expected fffffff1", hilo_rdata); else passed++;
        hiloren = 2'b00;
        #1;
        total++; if (hilo_rdata !== 32'd0) $display("FAIL noread_rdata: got %h expected 0", hilo_rdata); else passed++;
        tick;
        idle_in;
        #1;
        total++; if (hi !== 32'hFFFFFFFF) $display("FAIL mfhi_no_write: got %h expected ffffffff", hi); else passed++;
    endtask

    task automatic test_div;
        int c;
        run_op(0, 1, 1, 32'hFFFFFFF9, 32'd2, c);
        total++; if (c != 32) $display("FAIL div_cycles: got %0d expected 32", c); else passed++;
        total++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_lo: got %h expected fffffffd", lo); else passed++;
        total++; if (hi !== 32'hFFFFFFFF) $display("FAIL div_hi: got %h expected ffffffff", hi); else passed++;
        run_op(0, 1, 0, 32'd100, 32'd7, c);
        total++; if (lo !== 32'd14) $display("FAIL divu_lo: got %h expected 0000000e", lo); else passed++;
        total++; if (hi !== 32'd2) $display("FAIL divu_hi: got %h expected 00000002", hi); else passed++;
    endtask

    task automatic test_div_corner;
        int c;
        run_op(0, 1, 0, 32'h12345678, 32'd0, c);
        total++; if (c != 32) $display("FAIL divz_cycles: got %0d expected 32", c); else passed++;
        total++; if (lo !== 32'hFFFFFFFF) $display("FAIL divz_lo: got %h expected ffffffff", lo); else passed++;
        total++; if (hi !== 32'h12345678) $display("FAIL divz_hi: got %h expected 12345678", hi); else passed++;
        run_op(0, 1, 1, 32'hFFFFFFFB, 32'd0, c);
        total++; if (lo !== 32'h00000001) $display("FAIL sdivz_lo: got %h expected 00000001", lo); else passed++;
        total++; if (hi !== 32'hFFFFFFFB) $display("FAIL sdivz_hi: got %h expected fffffffb", hi); else passed++;
        run_op(0, 1, 1, 32'h80000000, 32'hFFFFFFFF, c);
        total++; if (lo !== 32'h80000000) $display("FAIL ovf_lo: got %h expected 80000000", lo); else passed++;
        total++; if (hi !== 32'd0) $display("FAIL ovf_hi: got %h expected 0", hi); else passed++;
    endtask

    task automatic test_flush;
        logic [31:0] h;
        en = 1; hilowen = 2'b01; rega = 32'h11;
        tick;
        idle_in;
        #1;
        total++; if (lo !== 32'h11) $display("FAIL flush_pre_lo: got %h expected 00000011", lo); else passed++;
        h = hi;
        en = 1; div = 1; mdsign = 1; hilowen = 2'b11;
        rega = 32'd100; regb = 32'd3;
        tick;
        idle_in;
        repeat (8) tick;
        total++; if (busy !== 1'b1) $display("FAIL flush_busy9: got %b expected 1", busy); else passed++;
        flush = 1;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL flush_busy10: got %b expected 0", busy); else passed++;
        tick;
        flush = 0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL flush_busy_after: got %b expected 0", busy); else passed++;
        repeat (40) tick;
        total++; if (lo !== 32'h11) $display("FAIL flush_lo: got %h expected 00000011", lo); else passed++;
        total++; if (hi !== h) $display("FAIL flush_hi: got %h expected %h", hi, h); else passed++;
        en = 1; hilowen = 2'b01; rega = 32'hA5;
        tick;
        idle_in;
        #1;
        total++; if (lo !== 32'hA5) $display("FAIL flush_mtlo: got %h expected 000000a5", lo); else passed++;
    endtask

    task automatic test_reset_mid;
        int c;
        en = 1; div = 1; hilowen = 2'b11;
        rega = 32'd1000; regb = 32'd9;
        tick;
        idle_in;
        repeat (5) tick;
        hiloren = 2'b01;
        #1;
        total++; if (hilo_rdata !== 32'hA5) $display("FAIL rstmid_pre: got %h expected 000000a5", hilo_rdata); else passed++;
        rst = 1;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else passed++;
        total++; if (hi !== 32'd0) $display("FAIL rstmid_hi: got %h expected 0", hi); else passed++;
        total++; if (lo !== 32'd0) $display("FAIL rstmid_lo: got %h expected 0", lo); else passed++;
        total++; if (hilo_rdata !== 32'd0) $display("FAIL rstmid_rdata: got %h expected 0", hilo_rdata); else passed++;
        tick;
        rst = 0;
        idle_in;
        repeat (40) tick;
        total++; if (lo !== 32'd0) $display("FAIL rstmid_nowrite: got %h expected 0", lo); else passed++;
        run_op(0, 1, 0, 32'd1000, 32'd9, c);
        total++; if (lo !== 32'd111) $display("FAIL rstmid_div_lo: got %h expected 0000006f", lo); else passed++;
        total++; if (hi !== 32'd1) $display("FAIL rstmid_div_hi: got %h expected 00000001", hi); else passed++;
    endtask

    initial begin
        test_reset;
        test_direct;
        test_multu;
        test_mult_mfhi;
        test_div;
        test_div_corner;
        test_flush;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
